// File: rtl/tick_generator.sv
// Programmable enable-tick source: divides Clk by Div+1 in RUN, or single-steps from a pushbutton.
// Define TICK_DEBOUNCE_EN to insert a DEBOUNCE_CYCLES stability filter on the Step path.
module tick_generator #(
  parameter int WIDTH           = 26,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Run,
  input  logic             Step,
  input  logic [WIDTH-1:0] Div,
  output logic             Tick,
  output logic             SlowClk,
  output logic [1:0]       State
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RUN       = 2'b01,
    STEP_WAIT = 2'b10
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] cnt_reg;
  logic             tick_reg;
  logic             slow_reg;

  logic             s1_reg;
  logic             s2_reg;
  logic             step_level;
  logic             step_rise;

  if (DEBOUNCE_CYCLES < 1) begin : g_check_debounce
    $error("tick_generator: DEBOUNCE_CYCLES must be at least 1");
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
    end else begin
      s1_reg <= Step;
      s2_reg <= s1_reg;
    end
  end

`ifdef TICK_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [DB_W-1:0] db_cnt_reg;
  logic            d_reg;
  logic            d_prev_reg;

  // d follows s2 only after s2 has disagreed with it for a full window of edges.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      db_cnt_reg <= '0;
      d_reg      <= 1'b0;
      d_prev_reg <= 1'b0;
    end else begin
      d_prev_reg <= d_reg;
      if (s2_reg == d_reg) begin
        db_cnt_reg <= '0;
      end else if (db_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        d_reg      <= s2_reg;
        db_cnt_reg <= '0;
      end else begin
        db_cnt_reg <= db_cnt_reg + 1'b1;
      end
    end
  end

  assign step_level = d_reg;
  assign step_rise  = d_reg & ~d_prev_reg;
`else
  logic s3_reg;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      s3_reg <= 1'b0;
    end else begin
      s3_reg <= s2_reg;
    end
  end

  assign step_level = s2_reg;
  assign step_rise  = s2_reg & ~s3_reg;
`endif

  // Cnt never passes Div; the >= compare forces a wrap when Div shrinks below Cnt.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      tick_reg  <= 1'b0;
      slow_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (Run) begin
            state_reg <= RUN;
            tick_reg  <= 1'b0;
          end else if (step_rise) begin
            state_reg <= STEP_WAIT;
            tick_reg  <= 1'b1;
            slow_reg  <= ~slow_reg;
          end else begin
            tick_reg  <= 1'b0;
          end
        end
        RUN: begin
          if (!Run) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            tick_reg  <= 1'b0;
          end else if (cnt_reg >= Div) begin
            cnt_reg   <= '0;
            tick_reg  <= 1'b1;
            slow_reg  <= ~slow_reg;
          end else begin
            cnt_reg   <= cnt_reg + 1'b1;
            tick_reg  <= 1'b0;
          end
        end
        STEP_WAIT: begin
          cnt_reg  <= '0;
          tick_reg <= 1'b0;
          if (Run) begin
            state_reg <= RUN;
          end else if (!step_level) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          tick_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign Tick    = tick_reg;
  assign SlowClk = slow_reg;
  assign State   = state_reg;

endmodule

// File: tb/tb_tick_generator.sv
// Self-checking bench for tick_generator: run-mode division, Div changes, Run drop, and Step presses.
// Expected ticks come from the period rule (every Div+1 edges after entry) and one-tick-per-press rule.
module tb_tick_generator;

  localparam int WIDTH = 26;
  localparam int DEB   = 4;
`ifdef TICK_DEBOUNCE_EN
  localparam int LAT    = 2 + DEB;
  localparam int MINLEN = DEB;
`else
  localparam int LAT    = 2;
  localparam int MINLEN = 1;
`endif
  localparam int SEQ_N = 256;

  logic             Clk = 1'b0;
  logic             Rst;
  logic             Run;
  logic             Step;
  logic [WIDTH-1:0] Div;
  logic             Tick;
  logic             SlowClk;
  logic [1:0]       State;

  int   n_cmp = 0;
  int   n_err = 0;
  logic slow_exp = 1'b0;

  bit   stim_a [SEQ_N];
  bit   exp_a  [SEQ_N];

  tick_generator #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
    .Clk(Clk), .Rst(Rst), .Run(Run), .Step(Step), .Div(Div),
    .Tick(Tick), .SlowClk(SlowClk), .State(State)
  );

  always #5 Clk = ~Clk;

  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  // Reference for step mode: each press of sufficient length yields one tick LAT edges after its first sample.
  task automatic clear_seq();
    for (int i = 0; i < SEQ_N; i++) begin
      stim_a[i] = 1'b0;
      exp_a[i]  = 1'b0;
    end
  endtask

  task automatic add_press(input int start, input int len);
    for (int i = start; i < start + len; i++) stim_a[i] = 1'b1;
    if (len >= MINLEN) exp_a[start + LAT] = 1'b1;
  endtask

  task automatic test_reset();
    int ticks;
    Rst = 1'b1; Run = 1'b1; Div = WIDTH'(3); Step = 1'b0;
    repeat (3) cycle();
    n_cmp++; if (Tick !== 1'b0)     begin n_err++; $display("FAIL reset_tick: got %b want 0", Tick); end
    n_cmp++; if (SlowClk !== 1'b0)  begin n_err++; $display("FAIL reset_slow: got %b want 0", SlowClk); end
    n_cmp++; if (State !== 2'b00)   begin n_err++; $display("FAIL reset_state: got %b want 00", State); end
    Rst = 1'b0;
    slow_exp = 1'b0;
    cycle();
    n_cmp++; if (State !== 2'b01) begin n_err++; $display("FAIL reset_entry_state: got %b want 01", State); end
    ticks = 0;
    for (int i = 1; i <= 16; i++) begin
      logic e;
      cycle();
      e = ((i % 4) == 0);
      if (e) begin slow_exp = ~slow_exp; ticks++; end
      n_cmp++; if (Tick !== e) begin n_err++; $display("FAIL reset_run_tick i=%0d: got %b want %b", i, Tick, e); end
      n_cmp++; if (SlowClk !== slow_exp) begin n_err++; $display("FAIL reset_run_slow i=%0d: got %b want %b", i, SlowClk, slow_exp); end
    end
    // asynchronous reset mid-run must clear outputs before the next edge
    #2; Rst = 1'b1; #1;
    n_cmp++; if (Tick !== 1'b0)    begin n_err++; $display("FAIL async_rst_tick: got %b want 0", Tick); end
    n_cmp++; if (SlowClk !== 1'b0) begin n_err++; $display("FAIL async_rst_slow: got %b want 0", SlowClk); end
    n_cmp++; if (State !== 2'b00)  begin n_err++; $display("FAIL async_rst_state: got %b want 00", State); end
    cycle();
    Rst = 1'b0; Run = 1'b0; slow_exp = 1'b0;
    cycle();
    $display("reset: div=3 ticks=%0d, async reset applied mid-run", ticks);
  endtask

  task automatic test_run(input int d, input int len, input string name);
    int ticks = 0;
    Div = WIDTH'(d); Run = 1'b1;
    cycle();
    n_cmp++; if (State !== 2'b01) begin n_err++; $display("FAIL %s_entry_state: got %b want 01", name, State); end
    n_cmp++; if (Tick !== 1'b0)   begin n_err++; $display("FAIL %s_entry_tick: got %b want 0", name, Tick); end
    for (int i = 1; i <= len; i++) begin
      logic e;
      cycle();
      e = ((i % (d + 1)) == 0);
      if (e) begin slow_exp = ~slow_exp; ticks++; end
      n_cmp++; if (Tick !== e) begin n_err++; $display("FAIL %s_tick i=%0d div=%0d: got %b want %b", name, i, d, Tick, e); end
      n_cmp++; if (SlowClk !== slow_exp) begin n_err++; $display("FAIL %s_slow i=%0d: got %b want %b", name, i, SlowClk, slow_exp); end
    end
    Run = 1'b0;
    cycle();
    n_cmp++; if (Tick !== 1'b0)   begin n_err++; $display("FAIL %s_drop_tick: got %b want 0", name, Tick); end
    n_cmp++; if (State !== 2'b00) begin n_err++; $display("FAIL %s_drop_state: got %b want 00", name, State); end
    cycle();
    n_cmp++; if (Tick !== 1'b0)   begin n_err++; $display("FAIL %s_idle_tick: got %b want 0", name, Tick); end
    $display("%s: div=%0d len=%0d ticks=%0d", name, d, len, ticks);
  endtask

  task automatic test_div_zero();
    test_run(0, 10, "div_zero");
  endtask

  task automatic test_run_drop();
    // drop Run one edge before a tick is due, then re-enter: count must restart from zero
    test_run(3, 7, "run_drop");
    test_run(3, 4, "run_reenter");
  endtask

  task automatic test_run_random();
    for (int t = 0; t < 8; t++) begin
      int d   = int'($urandom_range(0, 6));
      int len = int'($urandom_range(1, 3 * (d + 1) + 2));
      test_run(d, len, "run_rand");
    end
  endtask

  task automatic test_shrink_div();
    Div = WIDTH'(10); Run = 1'b1;
    cycle();
    for (int i = 1; i <= 7; i++) begin
      cycle();
      n_cmp++; if (Tick !== 1'b0) begin n_err++; $display("FAIL shrink_pre i=%0d: got %b want 0", i, Tick); end
    end
    Div = WIDTH'(2);
    for (int j = 1; j <= 9; j++) begin
      logic e;
      cycle();
      e = (((j - 1) % 3) == 0);
      if (e) slow_exp = ~slow_exp;
      n_cmp++; if (Tick !== e) begin n_err++; $display("FAIL shrink_tick j=%0d: got %b want %b", j, Tick, e); end
      n_cmp++; if (SlowClk !== slow_exp) begin n_err++; $display("FAIL shrink_slow j=%0d: got %b want %b", j, SlowClk, slow_exp); end
    end
    Run = 1'b0;
    cycle();
    n_cmp++; if (Tick !== 1'b0) begin n_err++; $display("FAIL shrink_drop_tick: got %b want 0", Tick); end
    $display("shrink_div: div 10 -> 2 at cnt=7");
  endtask

  task automatic test_step_press();
    int ticks = 0;
    Run = 1'b0; Div = WIDTH'(5);
    clear_seq();
    add_press(2, 20);
    for (int j = 0; j < 60; j++) begin
      Step = stim_a[j];
      cycle();
      if (exp_a[j]) begin slow_exp = ~slow_exp; ticks++; end
      n_cmp++; if (Tick !== exp_a[j]) begin n_err++; $display("FAIL step_tick j=%0d: got %b want %b", j, Tick, exp_a[j]); end
      n_cmp++; if (SlowClk !== slow_exp) begin n_err++; $display("FAIL step_slow j=%0d: got %b want %b", j, SlowClk, slow_exp); end
      if (j == 1 + LAT) begin
        n_cmp++; if (State !== 2'b00) begin n_err++; $display("FAIL step_pre_state: got %b want 00", State); end
      end
      if (j == 2 + LAT || j == 21) begin
        n_cmp++; if (State !== 2'b10) begin n_err++; $display("FAIL step_wait_state j=%0d: got %b want 10", j, State); end
      end
    end
    Step = 1'b0;
    n_cmp++; if (State !== 2'b00) begin n_err++; $display("FAIL step_release_state: got %b want 00", State); end
    $display("step_press: len=20 ticks=%0d", ticks);
  endtask

  task automatic test_bounce();
    int ticks = 0;
    Run = 1'b0;
    clear_seq();
    add_press(2, 2);
    add_press(7, 2);
    add_press(12, 2);
    add_press(25, 10);
    for (int j = 0; j < 70; j++) begin
      Step = stim_a[j];
      cycle();
      if (exp_a[j]) begin slow_exp = ~slow_exp; ticks++; end
      n_cmp++; if (Tick !== exp_a[j]) begin n_err++; $display("FAIL bounce_tick j=%0d: got %b want %b", j, Tick, exp_a[j]); end
    end
    Step = 1'b0;
    n_cmp++; if (SlowClk !== slow_exp) begin n_err++; $display("FAIL bounce_slow: got %b want %b", SlowClk, slow_exp); end
    $display("bounce: 3 glitches + 1 stable press, ticks=%0d", ticks);
  endtask

  task automatic test_step_random();
    int pos   = 2;
    int ticks = 0;
    int presses = 0;
    Run = 1'b0;
    clear_seq();
    while (pos + 12 + LAT + 20 < SEQ_N) begin
      int len = int'($urandom_range(1, 12));
      add_press(pos, len);
      presses++;
      pos += len + 10 + DEB + int'($urandom_range(0, 5));
    end
    for (int j = 0; j < SEQ_N; j++) begin
      Step = stim_a[j];
      cycle();
      if (exp_a[j]) begin slow_exp = ~slow_exp; ticks++; end
      n_cmp++; if (Tick !== exp_a[j]) begin n_err++; $display("FAIL step_rand_tick j=%0d: got %b want %b", j, Tick, exp_a[j]); end
      if (exp_a[j]) begin
        n_cmp++; if (State !== 2'b10) begin n_err++; $display("FAIL step_rand_state j=%0d: got %b want 10", j, State); end
      end
    end
    Step = 1'b0;
    n_cmp++; if (SlowClk !== slow_exp) begin n_err++; $display("FAIL step_rand_slow: got %b want %b", SlowClk, slow_exp); end
    $display("step_random: presses=%0d ticks=%0d", presses, ticks);
  endtask

  initial begin
    Rst = 1'b1; Run = 1'b0; Step = 1'b0; Div = '0;
    test_reset();
    test_div_zero();
    test_shrink_div();
    test_run_drop();
    test_run_random();
    test_step_press();
    test_bounce();
    test_step_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
